// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered N-to-2^N one-hot decoder with DIRECT and SCAN modes.
//   DIRECT: a load strobe captures d and drives one-hot(d) on y one cycle later.
//   SCAN  : the asserted line walks 0..2^N-1 (or from a loaded start index),
//           each line held for DWELL cycles; wrap pulses on the 2^N-1 -> 0 step.
// Optional build macro DEC_SKIP_MASK_EN adds a skip_mask input; masked lines are
// skipped during SCAN and consume no dwell. Without the macro every line is visited.
//
// Parameters:
//   N          select width, y is 2**N wide (1..6)
//   DWELL      cycles per line in SCAN (1..255)
//   ACTIVE_LOW 1 inverts y only
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         block enable, 0 forces outputs idle
//   mode       0 = DIRECT, 1 = SCAN
//   load       strobe capturing d
//   d          select value / scan start index
//   skip_mask  (DEC_SKIP_MASK_EN only) per-line scan skip
//   y          registered one-hot output
//   idx        index of the currently asserted line
//   wrap       one-cycle pulse on scan wrap
//   busy       high while in SCAN
module decoder_n_scan #(
  parameter int unsigned N          = 3,
  parameter int unsigned DWELL      = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic            load,
  input  logic [N-1:0]    d,
`ifdef DEC_SKIP_MASK_EN
  input  logic [2**N-1:0] skip_mask,
`endif
  output logic [2**N-1:0] y,
  output logic [N-1:0]    idx,
  output logic            wrap,
  output logic            busy
);

  localparam int unsigned OW = 2**N;
  localparam int unsigned DW = 8;
  localparam logic [OW-1:0] Y_IDLE = ACTIVE_LOW ? {OW{1'b1}} : {OW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t          state;
  logic [DW-1:0]   dwell;
  logic [OW-1:0]   mask;

`ifdef DEC_SKIP_MASK_EN
  assign mask = skip_mask;
`else
  assign mask = {OW{1'b0}};
`endif

  // One-hot pattern for a line index, before polarity.
  function automatic logic [OW-1:0] one_hot(input logic [N-1:0] i);
    logic [OW-1:0] v;
    v    = {OW{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  // Apply output polarity.
  function automatic logic [OW-1:0] drive(input logic [OW-1:0] v);
    return ACTIVE_LOW ? ~v : v;
  endfunction

  // First unmasked index at/after start (skip=0) or strictly after start (skip=1),
  // circularly. Returns start when every line is masked.
  function automatic logic [N-1:0] seek_pos(input logic [N-1:0]  start,
                                            input logic          skip,
                                            input logic [OW-1:0] m);
    logic [N-1:0] pos;
    logic [N-1:0] cand;
    logic         hit;
    pos = start;
    hit = 1'b0;
    for (int unsigned k = 0; k < OW; k++) begin
      cand = N'(32'(start) + k + 32'(skip));
      if (!hit && !m[cand]) begin
        hit = 1'b1;
        pos = cand;
      end
    end
    return pos;
  endfunction

  // True when the advance from start to the next unmasked line passes index OW-1.
  function automatic logic seek_wrap(input logic [N-1:0]  start,
                                     input logic [OW-1:0] m);
    logic [31:0]  s;
    logic [N-1:0] cand;
    logic         hit;
    logic         wr;
    hit = 1'b0;
    wr  = 1'b0;
    for (int unsigned k = 0; k < OW; k++) begin
      s    = 32'(start) + k + 32'd1;
      cand = N'(s);
      if (!hit && !m[cand]) begin
        hit = 1'b1;
        wr  = (s >= OW);
      end
    end
    return wr;
  endfunction

  logic [N-1:0] ent_base;
  logic [N-1:0] ent_idx;
  logic [N-1:0] adv_idx;
  logic         adv_wrap;
  logic [N-1:0] cur_idx;
  logic         any_free;
  logic         cur_masked;
  logic         dwell_done;

  // Candidate indices for scan entry, normal advance and mask-change recovery.
  always_comb begin
    ent_base   = load ? d : {N{1'b0}};
    ent_idx    = seek_pos(ent_base, 1'b0, mask);
    adv_idx    = seek_pos(idx, 1'b1, mask);
    adv_wrap   = seek_wrap(idx, mask);
    cur_idx    = seek_pos(idx, 1'b0, mask);
    any_free   = |(~mask);
    cur_masked = mask[idx];
    dwell_done = (dwell == DW'(DWELL - 1));
  end

  // State machine; priority rst > !en > load > mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      dwell <= '0;
      idx   <= '0;
      y     <= Y_IDLE;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else if (!en) begin
      state <= ST_IDLE;
      dwell <= '0;
      y     <= Y_IDLE;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else if (load && !mode) begin
      state <= ST_DIRECT;
      dwell <= '0;
      idx   <= d;
      y     <= drive(one_hot(d));
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else if (mode && (load || state != ST_SCAN)) begin
      // Scan entry or restart; never pulses wrap.
      state <= ST_SCAN;
      dwell <= '0;
      wrap  <= 1'b0;
      busy  <= 1'b1;
      if (any_free) begin
        idx <= ent_idx;
        y   <= drive(one_hot(ent_idx));
      end else begin
        y   <= Y_IDLE;
      end
    end else if (mode) begin
      busy <= 1'b1;
      if (!any_free) begin
        // Everything masked: park with no line asserted.
        dwell <= '0;
        y     <= Y_IDLE;
        wrap  <= 1'b0;
      end else if (cur_masked || y == Y_IDLE) begin
        // Mask changed under us: move to the nearest allowed line.
        dwell <= '0;
        idx   <= cur_idx;
        y     <= drive(one_hot(cur_idx));
        wrap  <= 1'b0;
      end else if (dwell_done) begin
        dwell <= '0;
        idx   <= adv_idx;
        y     <= drive(one_hot(adv_idx));
        wrap  <= adv_wrap;
      end else begin
        dwell <= dwell + DW'(1);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
      if (state == ST_SCAN) begin
        // Leaving SCAN freezes the current line in DIRECT.
        state <= ST_DIRECT;
        dwell <= '0;
        y     <= drive(one_hot(idx));
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decoder_n_scan.sv
module tb_decoder_n_scan;

  logic clk = 1'b0;
  logic rst, en, mode, load;
  logic [2:0] d;
  logic [7:0] ya;
  logic [2:0] idxa;
  logic       wrapa, busya;
  logic [1:0] yb;
  logic       idxb, wrapb, busyb;
`ifdef DEC_SKIP_MASK_EN
  logic [7:0] mask_a = 8'h00;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  decoder_n_scan #(.N(3), .DWELL(4), .ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .d(d),
`ifdef DEC_SKIP_MASK_EN
    .skip_mask(mask_a),
`endif
    .y(ya), .idx(idxa), .wrap(wrapa), .busy(busya)
  );

  decoder_n_scan #(.N(1), .DWELL(1), .ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .d(d[0]),
`ifdef DEC_SKIP_MASK_EN
    .skip_mask(2'b00),
`endif
    .y(yb), .idx(idxb), .wrap(wrapb), .busy(busyb)
  );

  // Reference model: 0 = idle, 1 = direct, 2 = scanning. During a scan the
  // line is derived from elapsed time since the scan (re)start.
  int kind [2];
  int m_idx [2];
  int m_start [2];
  int m_t [2];
  bit m_wrap [2];

  function automatic int ow(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  function automatic int dw(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic void model_step(input int i, input bit r, input bit e,
                                     input bit md, input bit ld, input int dv);
    m_wrap[i] = 1'b0;
    if (r) begin
      kind[i]  = 0;
      m_idx[i] = 0;
    end else if (!e) begin
      kind[i] = 0;
    end else if (ld && !md) begin
      kind[i]  = 1;
      m_idx[i] = dv;
    end else if (md && (ld || kind[i] != 2)) begin
      kind[i]    = 2;
      m_start[i] = ld ? dv : 0;
      m_t[i]     = 0;
      m_idx[i]   = m_start[i];
    end else if (md) begin
      m_t[i]    = m_t[i] + 1;
      m_idx[i]  = (m_start[i] + m_t[i] / dw(i)) % ow(i);
      m_wrap[i] = (m_t[i] % dw(i) == 0) && (m_idx[i] == 0);
    end else if (kind[i] == 2) begin
      kind[i] = 1;
    end
  endfunction

  function automatic logic [17:0] exp_vec();
    logic [7:0] ea;
    logic [1:0] eb;
    ea = (kind[0] == 0) ? 8'h00 : 8'(1 << m_idx[0]);
    eb = (kind[1] == 0) ? 2'b11 : ~2'(1 << m_idx[1]);
    return {ea, 3'(m_idx[0]), m_wrap[0], kind[0] == 2,
            eb, 1'(m_idx[1]), m_wrap[1], kind[1] == 2};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {ya, idxa, wrapa, busya, yb, idxb, wrapb, busyb};
  endfunction

  // One clock: advance the model with the inputs present at the edge.
  task automatic step();
    @(posedge clk);
    model_step(0, rst, en, mode, load, int'(d));
    model_step(1, rst, en, mode, load, int'(d[0]));
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; d = 3'd0;
    repeat (2) begin
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL reset cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0;
    repeat (2) begin
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL reset_en0 cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
    end
    en = 1'b1;
    repeat (2) begin
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL idle_hold cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_direct();
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load = 1'b1; d = 3'(i);
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL direct_load cyc%0d d=%0d: got %h expected %h", cyc, i, obs_vec(), exp_vec());
      end
      load = 1'b0; d = 3'($urandom);
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL direct_hold cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; mode = 1'b0; load = 1'b1;
    repeat (10) begin
      d = 3'($urandom);
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL back_to_back cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
    end
    load = 1'b0;
  endtask

  task automatic test_scan();
    int wraps;
    wraps = 0;
    en = 1'b0; load = 1'b0; mode = 1'b0;
    step();
    en = 1'b1; mode = 1'b1;
    for (int t = 0; t < 70; t++) begin
      step();
      if (wrapa === 1'b1) wraps++;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL scan cyc%0d t=%0d: got %h expected %h", cyc, t, obs_vec(), exp_vec());
      end
    end
    tests++;
    if (wraps != 69 / 32) begin
      fails++;
      $display("FAIL scan_wrap_count: got %0d expected %0d", wraps, 69 / 32);
    end
  endtask

  task automatic test_mid_scan();
    en = 1'b1; mode = 1'b1; load = 1'b1; d = 3'd5;
    step();
    tests++;
    if (ya !== 8'h20 || idxa !== 3'd5 || obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL mid_load cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
    end
    load = 1'b0;
    repeat (6) begin
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL mid_dwell cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
    end
    load = 1'b1; d = 3'd5;
    step();
    load = 1'b0;
    step();
    mode = 1'b0;
    repeat (3) begin
      step();
      tests++;
      if (ya !== 8'h20 || busya !== 1'b0 || obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL mid_freeze cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
    end
    en = 1'b0;
    repeat (2) begin
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL mid_disable cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit hit;
    hit = 1'b0;
    en = 1'b1; mode = 1'b1; load = 1'b0; rst = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL pre_reset_scan cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      if (m_idx[0] == 6 && m_t[0] % 4 == 1) hit = 1'b1;
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL reset_mid_scan_reach: got idx %0d expected 6", idxa);
    end
    rst = 1'b1;
    step();
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL reset_mid_scan cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst  = ($urandom % 60) == 0;
      en   = ($urandom % 10) != 0;
      mode = ($urandom % 4) != 0;
      load = ($urandom % 8) == 0;
      d    = 3'($urandom);
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0; load = 1'b0;
  endtask

`ifdef DEC_SKIP_MASK_EN
  task automatic test_mask();
    int vis [4];
    int pos;
    int e_idx;
    bit e_wrap;
    vis = '{0, 2, 4, 6};
    rst = 1'b1; en = 1'b1; mode = 1'b1; load = 1'b0;
    step();
    rst = 1'b0; mask_a = 8'hAA;
    for (int t = 0; t < 40; t++) begin
      step();
      pos    = (t / 4) % 4;
      e_idx  = vis[pos];
      e_wrap = (t > 0) && (t % 4 == 0) && (pos == 0);
      tests++;
      if ({ya, idxa, wrapa, busya} !== {8'(1 << e_idx), 3'(e_idx), e_wrap, 1'b1}) begin
        fails++;
        $display("FAIL mask_scan t=%0d: got y=%h idx=%0d wrap=%b expected y=%h idx=%0d wrap=%b",
                 t, ya, idxa, wrapa, 8'(1 << e_idx), e_idx, e_wrap);
      end
    end
    mask_a = 8'hFF; rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (20) begin
      step();
      tests++;
      if ({ya, idxa, wrapa, busya} !== {8'h00, 3'd0, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL mask_all: got y=%h idx=%0d wrap=%b busy=%b expected 00 0 0 1",
                 ya, idxa, wrapa, busya);
      end
    end
    mask_a = 8'h00; rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_direct();
    test_back_to_back();
    test_scan();
    test_mid_scan();
    test_reset_mid_scan();
    test_random();
`ifdef DEC_SKIP_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
